// File: rtl/comma_aligner.sv
// K28.5 comma aligner: searches all 10 bit offsets, barrel-shifts to the comma boundary, tracks lock.
// Define ALIGN_ERR_CNT_EN to add align_err_count, a saturating count of foreign commas while locked.
module comma_aligner #(
  parameter int unsigned DATA_WIDTH    = 10,
  parameter int unsigned LOCK_COMMAS   = 3,
  parameter int unsigned UNLOCK_COMMAS = 2
) (
  input  logic                  write_clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  comma_det,
  output logic                  symbol_lock,
  output logic [3:0]            align_offset
`ifdef ALIGN_ERR_CNT_EN
  ,
  output logic [7:0]            align_err_count
`endif
);

  localparam logic [DATA_WIDTH-1:0] KNeg = 10'b0101111100;
  localparam logic [DATA_WIDTH-1:0] KPos = 10'b1010000011;
  localparam int unsigned CntW  = $clog2(LOCK_COMMAS + 1);
  localparam int unsigned MissW = $clog2(UNLOCK_COMMAS + 1);

  typedef enum logic [1:0] {StHunt, StVerify, StLocked} state_e;

  state_e                    state_q;
  logic [DATA_WIDTH-1:0]     prev_q;
  logic [3:0]                off_q;
  logic [CntW-1:0]           cnt_q;
  logic [MissW-1:0]          miss_q;
`ifdef ALIGN_ERR_CNT_EN
  logic [7:0]                err_q;
`endif

  logic [2*DATA_WIDTH-1:0]   window;
  logic [DATA_WIDTH-1:0]     match;
  logic                      hit;
  logic                      on_off;
  logic [3:0]                hit_k;
  logic [3:0]                off_n;
  logic [4:0]                sel;

  assign window = {data_in, prev_q};

  // Descending scan so the lowest matching offset is the last one written and wins.
  always_comb begin
    match = '0;
    hit_k = '0;
    for (int k = DATA_WIDTH - 1; k >= 0; k--) begin
      match[k] = (window[k +: DATA_WIDTH] == KNeg) || (window[k +: DATA_WIDTH] == KPos);
      if (match[k]) hit_k = 4'(k);
    end
  end

  assign hit    = |match;
  assign on_off = match[off_q];

  // Offset taken this cycle, so the comma that moves the offset is itself emitted aligned.
  always_comb begin
    off_n = off_q;
    if ((state_q == StHunt) && hit) begin
      off_n = hit_k;
    end else if ((state_q == StVerify) && hit && !on_off) begin
      off_n = hit_k;
    end
  end

  assign sel = {1'b0, off_n};

  always_ff @(posedge write_clk) begin
    if (rst) begin
      state_q   <= StHunt;
      prev_q    <= '0;
      off_q     <= '0;
      cnt_q     <= '0;
      miss_q    <= '0;
      data_out  <= '0;
      comma_det <= 1'b0;
`ifdef ALIGN_ERR_CNT_EN
      err_q     <= '0;
`endif
    end else begin
      prev_q    <= data_in;
      data_out  <= window[sel +: DATA_WIDTH];
      comma_det <= match[off_n];
      off_q     <= off_n;
      unique case (state_q)
        StHunt: begin
          if (hit) begin
            cnt_q <= CntW'(1);
            if (LOCK_COMMAS <= 1) begin
              state_q <= StLocked;
              miss_q  <= '0;
            end else begin
              state_q <= StVerify;
            end
          end
        end
        StVerify: begin
          if (on_off) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q >= CntW'(LOCK_COMMAS - 1)) begin
              state_q <= StLocked;
              miss_q  <= '0;
            end
          end else if (hit) begin
            cnt_q <= CntW'(1);
          end
        end
        StLocked: begin
          if (on_off) begin
            miss_q <= '0;
          end else if (hit) begin
`ifdef ALIGN_ERR_CNT_EN
            if (err_q != 8'hFF) err_q <= err_q + 1'b1;
`endif
            if (miss_q >= MissW'(UNLOCK_COMMAS - 1)) begin
              state_q <= StHunt;
              miss_q  <= '0;
            end else begin
              miss_q <= miss_q + 1'b1;
            end
          end
        end
        default: state_q <= StHunt;
      endcase
    end
  end

  assign symbol_lock  = (state_q == StLocked);
  assign align_offset = off_q;
`ifdef ALIGN_ERR_CNT_EN
  assign align_err_count = err_q;
`endif

endmodule
